// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: two-requester arbiter and sequencer for a single-port main
// memory. It accepts line-wide read/write requests, serves one at a time, drives
// the memory's address/data/enables, waits out the read latency and then returns
// a one-cycle acknowledge (with read data) to the winner.
// Build option: define MAIN_MEM_ARB_FIXED_PRIO_EN for fixed priority (r0 wins
// when both requesters are pending); leave it undefined for round-robin.
module main_mem_arbiter #(
  parameter int N            = 32,
  parameter int WORDSPERLINE = 2,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      r0_req,
  input  logic                      r0_we,
  input  logic [N-1:0]              r0_addr,
  input  logic [WORDSPERLINE*N-1:0] r0_wdata,
  output logic                      r0_ack,
  output logic [WORDSPERLINE*N-1:0] r0_rdata,
  input  logic                      r1_req,
  input  logic                      r1_we,
  input  logic [N-1:0]              r1_addr,
  input  logic [WORDSPERLINE*N-1:0] r1_wdata,
  output logic                      r1_ack,
  output logic [WORDSPERLINE*N-1:0] r1_rdata,
  output logic [N-1:0]              mem_addr,
  output logic [WORDSPERLINE*N-1:0] mem_data_in,
  output logic                      mem_re,
  output logic                      mem_we,
  input  logic [WORDSPERLINE*N-1:0] mem_data_out,
  output logic                      busy,
  output logic                      grant_id
);

  localparam int LW = WORDSPERLINE * N;
  // Counter start value; MEM_LATENCY is limited to 1..7 so three bits suffice.
  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic            lat_we_q;
  logic [2:0]      cnt_q;
`ifndef MAIN_MEM_ARB_FIXED_PRIO_EN
  // Requester favoured on a tie: the one not granted most recently.
  logic            prio_q;
`endif

  logic            r0_ack_q;
  logic            r1_ack_q;
  logic [LW-1:0]   r0_rdata_q;
  logic [LW-1:0]   r1_rdata_q;
  logic [N-1:0]    mem_addr_q;
  logic [LW-1:0]   mem_data_in_q;
  logic            mem_re_q;
  logic            mem_we_q;
  logic            busy_q;
  logic            grant_id_q;

  logic            sel_valid_d;
  logic            sel_id_d;
  logic            sel_we_d;
  logic [N-1:0]    sel_addr_d;
  logic [LW-1:0]   sel_wdata_d;

  // Pick the winner among pending requesters and mux its transaction fields.
  always_comb begin
    sel_valid_d = r0_req | r1_req;
    sel_id_d    = 1'b0;
    if (r0_req && r1_req) begin
`ifdef MAIN_MEM_ARB_FIXED_PRIO_EN
      sel_id_d = 1'b0;
`else
      sel_id_d = prio_q;
`endif
    end else if (r1_req) begin
      sel_id_d = 1'b1;
    end else begin
      sel_id_d = 1'b0;
    end

    if (sel_id_d) begin
      sel_we_d    = r1_we;
      sel_addr_d  = r1_addr;
      sel_wdata_d = r1_wdata;
    end else begin
      sel_we_d    = r0_we;
      sel_addr_d  = r0_addr;
      sel_wdata_d = r0_wdata;
    end
  end

  // Sequencer FSM: every output is a register updated on the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lat_we_q      <= 1'b0;
      cnt_q         <= 3'd0;
`ifndef MAIN_MEM_ARB_FIXED_PRIO_EN
      prio_q        <= 1'b0;
`endif
      r0_ack_q      <= 1'b0;
      r1_ack_q      <= 1'b0;
      r0_rdata_q    <= '0;
      r1_rdata_q    <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      grant_id_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_valid_d) begin
            // Latch the winner; memory strobes are set here so they are
            // already valid during the ISSUE cycle.
            grant_id_q <= sel_id_d;
            lat_we_q   <= sel_we_d;
            mem_addr_q <= sel_addr_d;
            busy_q     <= 1'b1;
            if (sel_we_d) begin
              mem_we_q      <= 1'b1;
              mem_data_in_q <= sel_wdata_d;
            end else begin
              mem_re_q <= 1'b1;
            end
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_ISSUE: begin
          if (lat_we_q) begin
            mem_we_q <= 1'b0;
            if (grant_id_q) begin
              r1_ack_q <= 1'b1;
            end else begin
              r0_ack_q <= 1'b1;
            end
            state_q <= S_RESP;
          end else begin
            // Read stays asserted (address held) for the whole WAIT phase.
            cnt_q   <= LAT_INIT;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt_q == 3'd1) begin
            mem_re_q <= 1'b0;
            if (grant_id_q) begin
              r1_rdata_q <= mem_data_out;
              r1_ack_q   <= 1'b1;
            end else begin
              r0_rdata_q <= mem_data_out;
              r0_ack_q   <= 1'b1;
            end
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end

        S_RESP: begin
          r0_ack_q <= 1'b0;
          r1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
`ifndef MAIN_MEM_ARB_FIXED_PRIO_EN
          prio_q   <= ~grant_id_q;
`endif
          state_q  <= S_IDLE;
        end

        default: begin
          r0_ack_q <= 1'b0;
          r1_ack_q <= 1'b0;
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign r0_ack      = r0_ack_q;
  assign r1_ack      = r1_ack_q;
  assign r0_rdata    = r0_rdata_q;
  assign r1_rdata    = r1_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench for main_mem_arbiter. A behavioural memory device answers
// the DUT; a transaction-level reference model predicts grant order, ack cycles,
// memory strobes and read data from the arbitration and latency rules.
module tb_main_mem_arbiter;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;
`ifdef MAIN_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r1_addr;
  logic [63:0] r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [63:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr;
  logic [63:0] mem_data_in, mem_data_out;
  logic        mem_re, mem_we, busy, grant_id;

  // second instance with MEM_LATENCY = 3, exercised through requester 1 only
  logic        b_r1_req;
  logic [31:0] b_r1_addr;
  logic        b_r0_ack, b_r1_ack;
  logic [63:0] b_r0_rdata, b_r1_rdata;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_data_in, b_mem_data_out;
  logic        b_mem_re, b_mem_we, b_busy, b_grant_id;

  logic [63:0] init_mem [256];
  logic [63:0] dev_mem  [256];
  logic [63:0] mmodel   [256];
  logic        preload_go;
  logic [63:0] pipe1;
  logic [63:0] pipe3 [3];

  logic        model_pref;
  logic [63:0] last_rd [2];
  int          n_assert;
  int          n_fail;

  main_mem_arbiter #(.N(32), .WORDSPERLINE(2), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_re(mem_re),
    .mem_we(mem_we), .mem_data_out(mem_data_out), .busy(busy), .grant_id(grant_id)
  );

  main_mem_arbiter #(.N(32), .WORDSPERLINE(2), .MEM_LATENCY(LAT3)) dut3 (
    .clk(clk), .rst(rst),
    .r0_req(1'b0), .r0_we(1'b0), .r0_addr(32'h0), .r0_wdata(64'h0),
    .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
    .r1_req(b_r1_req), .r1_we(1'b0), .r1_addr(b_r1_addr), .r1_wdata(64'h0),
    .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
    .mem_addr(b_mem_addr), .mem_data_in(b_mem_data_in), .mem_re(b_mem_re),
    .mem_we(b_mem_we), .mem_data_out(b_mem_data_out), .busy(b_busy), .grant_id(b_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory device: 256 lines indexed by address[7:0], registered read data
  always @(posedge clk) begin
    if (preload_go) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_mem[i];
    end else if (mem_we) begin
      dev_mem[mem_addr[7:0]] <= mem_data_in;
    end
    pipe1    <= dev_mem[mem_addr[7:0]];
    pipe3[0] <= dev_mem[b_mem_addr[7:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_data_out   = pipe1;
  assign b_mem_data_out = pipe3[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one transaction on each requester flagged in p0/p1 (same cycle),
  // predict the whole schedule, then check every cycle until both are served.
  task automatic run_pair(input logic p0, input logic we0, input logic [31:0] a0, input logic [63:0] d0,
                          input logic p1, input logic we1, input logic [31:0] a1, input logic [63:0] d1);
    logic        sv [2];
    logic        pd [2];
    logic        wv [2];
    logic [31:0] av [2];
    logic [63:0] dv [2];
    logic [63:0] er [2];
    int          ta [2];
    int          tk [2];
    int          t, w, last;
    logic        e_re, e_we, e_busy;
    logic [31:0] e_addr;
    logic [63:0] e_din;
    int          e_gid;
    sv[0] = p0; sv[1] = p1; pd[0] = p0; pd[1] = p1;
    wv[0] = we0; wv[1] = we1; av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
    er[0] = 64'h0; er[1] = 64'h0;
    ta[0] = -100; ta[1] = -100; tk[0] = -100; tk[1] = -100;
    t = 0; w = 0; last = 0;
    // reference schedule
    while (pd[0] || pd[1]) begin
      if (pd[0] && pd[1]) w = FIXED ? 0 : int'(model_pref);
      else w = pd[0] ? 0 : 1;
      ta[w] = t;
      tk[w] = t + (wv[w] ? 2 : 2 + LAT);
      if (wv[w]) mmodel[av[w][7:0]] = dv[w];
      else er[w] = mmodel[av[w][7:0]];
      model_pref = (w == 0) ? 1'b1 : 1'b0;
      pd[w] = 1'b0;
      last = tk[w];
      t = tk[w] + 1;
    end
    r0_req = p0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_req = p1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      e_re = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_addr = 32'h0; e_din = 64'h0; e_gid = -1;
      for (int k = 0; k < 2; k++) begin
        if (sv[k]) begin
          if (n >= ta[k] + 1 && n <= tk[k]) begin e_busy = 1'b1; e_gid = k; end
          if (!wv[k] && n >= ta[k] + 1 && n <= ta[k] + 1 + LAT) begin e_re = 1'b1; e_addr = av[k]; end
          if (wv[k] && n == ta[k] + 1) begin e_we = 1'b1; e_addr = av[k]; e_din = dv[k]; end
        end
      end
      chk("busy", busy, e_busy);
      chk("mem_re", mem_re, e_re);
      chk("mem_we", mem_we, e_we);
      if (e_re || e_we) chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_data_in", mem_data_in, e_din);
      if (e_gid >= 0) chk("grant_id", grant_id, e_gid == 1);
      chk("r0_ack", r0_ack, sv[0] && n == tk[0]);
      chk("r1_ack", r1_ack, sv[1] && n == tk[1]);
      if (sv[0] && n == tk[0]) begin
        chk("r0_rdata", r0_rdata, wv[0] ? last_rd[0] : er[0]);
        if (!wv[0]) last_rd[0] = er[0];
        r0_req = 1'b0;
      end
      if (sv[1] && n == tk[1]) begin
        chk("r1_rdata", r1_rdata, wv[1] ? last_rd[1] : er[1]);
        if (!wv[1]) last_rd[1] = er[1];
        r1_req = 1'b0;
      end
    end
  endtask

  initial begin
    logic        p0, p1, w0, w1;
    logic [31:0] a0, a1;
    n_assert = 0; n_fail = 0;
    rst = 1'b1; preload_go = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 32'h0; r0_wdata = 64'h0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 32'h0; r1_wdata = 64'h0;
    b_r1_req = 1'b0; b_r1_addr = 32'h0;
    model_pref = 1'b0; last_rd[0] = 64'h0; last_rd[1] = 64'h0;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = {$urandom, $urandom};
      mmodel[i]   = init_mem[i];
    end
    init_mem[8'h10] = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    mmodel[8'h10]   = init_mem[8'h10];
    repeat (3) @(negedge clk);
    preload_go = 1'b0;

    // reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_re", mem_re, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_acks", {r0_ack, r1_ack}, 2'b00);
    chk("rst_rdata0", r0_rdata, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // directed: single read of 0x10, write then readback, contention
    run_pair(1'b1, 1'b0, 32'h10, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0);
    run_pair(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 32'h20, {32'h2222_2222, 32'h1111_1111});
    run_pair(1'b1, 1'b0, 32'h01, 64'h0, 1'b1, 1'b0, 32'h02, 64'h0);
    run_pair(1'b1, 1'b0, 32'h01, 64'h0, 1'b1, 1'b0, 32'h02, 64'h0);
    run_pair(1'b1, 1'b0, 32'h20, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0);
    chk("readback_0x20", r0_rdata, {32'h2222_2222, 32'h1111_1111});

    // reset asserted while the read is in WAIT
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_re", mem_re, 1'b0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_grant", grant_id, 1'b0);
    chk("mid_rst_rdata0", r0_rdata, 64'h0);
    @(negedge clk);
    chk("mid_rst_noack", {r0_ack, r1_ack}, 2'b00);
    rst = 1'b0;
    model_pref = 1'b0; last_rd[0] = 64'h0; last_rd[1] = 64'h0;
    run_pair(1'b1, 1'b0, 32'h10, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0);

    // MEM_LATENCY = 3 instance: r1 reads 0x05
    b_r1_addr = 32'h05; b_r1_req = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      chk("l3_ack", b_r1_ack, n == 5);
      if (n <= 4) begin
        chk("l3_re", b_mem_re, 1'b1);
        chk("l3_addr", b_mem_addr, 32'h05);
      end else begin
        chk("l3_re_off", b_mem_re, 1'b0);
      end
      if (n == 5) begin
        chk("l3_rdata", b_r1_rdata, mmodel[8'h05]);
        b_r1_req = 1'b0;
      end
    end

    // randomized transactions against the reference model
    for (int it = 0; it < 40; it++) begin
      p0 = 1'($urandom_range(0, 1));
      p1 = p0 ? 1'($urandom_range(0, 1)) : 1'b1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      a0 = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 8'($urandom_range(0, 15))};
      a1 = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 8'($urandom_range(0, 15))};
      run_pair(p0, w0, a0, {$urandom, $urandom}, p1, w1, a1, {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
